// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared RAM port, burst-limited, one dead cycle between owners.
// Define CPU_PRIORITY_EN to give master 0 absolute priority and exemption from the burst limit.
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] m_addr,
    input  logic [NUM_REQ*DW-1:0] m_wdata,
    input  logic [NUM_REQ-1:0]    m_we,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [DW-1:0]         rd_data
);

    localparam int unsigned NR = NUM_REQ;
    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DW-1:0]      rd_data_q, rd_data_d;

    logic               found;
    logic [OW-1:0]      cand;
    logic [OW-1:0]      winner;
    logic               own_req;
    logic               others_req;
    logic               release_own;

    // Rotating search starting just after the previous owner.
    always_comb begin
        found  = 1'b0;
        cand   = '0;
        winner = owner_q;
`ifdef CPU_PRIORITY_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = OW'((32'(owner_q) + k) % NR);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt_q[i]) begin
                mem_addr  = mem_addr  | m_addr[i*AW +: AW];
                mem_wdata = mem_wdata | m_wdata[i*DW +: DW];
            end
        end
        own_req    = req[owner_q];
        mem_en     = own_req & gnt_q[owner_q];
        mem_we     = mem_en & m_we[owner_q];
        others_req = |(req & ~gnt_q);

        release_own = ~own_req;
`ifdef CPU_PRIORITY_EN
        if (owner_q != '0 && mem_en &&
            (req[0] || (burst_cnt_q == BURST_TOP && others_req))) begin
            release_own = 1'b1;
        end
`else
        if (mem_en && burst_cnt_q == BURST_TOP && others_req) begin
            release_own = 1'b1;
        end
`endif
    end

    // The dead cycle also arbitrates, so gnt is low for exactly one cycle between owners.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                state_d = ST_IDLE;
                if (|req) begin
                    state_d         = ST_OWN;
                    gnt_d           = '0;
                    gnt_d[winner]   = 1'b1;
                    owner_d         = winner;
                    burst_cnt_d     = '0;
                end
            end
            ST_OWN: begin
                if (mem_en && burst_cnt_q != BURST_TOP) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
                if (release_own) begin
                    state_d = ST_TURN;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // RAM data arrives one cycle after the strobe; valid and data are registered together.
    always_comb begin
        rd_pend_d  = (mem_en && !mem_we) ? gnt_q : '0;
        rd_valid_d = rd_pend_q;
        rd_data_d  = (|rd_pend_q) ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= LAST_IDX;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign gnt      = gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a grant/ownership model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int MAX_BURST = 8;
    localparam int VW        = 2*NUM_REQ + 2 + AW + 2*DW;

    logic                  clk = 1'b0;
    logic                  n_reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] m_addr;
    logic [NUM_REQ*DW-1:0] m_wdata;
    logic [NUM_REQ-1:0]    m_we;
    logic [NUM_REQ-1:0]    gnt;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [DW-1:0]         rd_data;

    bus_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .n_reset(n_reset), .req(req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after the strobe.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    logic [VW-1:0] obs;
    assign obs = {gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data};

    int n_vec, n_err;

    // Reference model: who owns the port, how many accesses it made, pending read returns.
    typedef struct { int due; int who; logic [DW-1:0] data; } rd_t;
    rd_t rq[$];
    int  m_owner, m_last, m_acc, cyc;
    logic [DW-1:0]      m_rd;
    logic [NUM_REQ-1:0] e_gnt, e_rdv;
    logic               e_en, e_we;
    logic [VW-1:0]      exp_v;

    function automatic logic bit_of(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (bit_of(v, i)) return i;
        return -1;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] r);
`ifdef CPU_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (bit_of(r, (m_last + k) % NUM_REQ)) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = NUM_REQ - 1;
        m_acc   = 0;
        m_rd    = '0;
        rq.delete();
    endtask

    task automatic predict();
        logic [NUM_REQ-1:0] eg, erv;
        logic               een, ewe;
        logic [AW-1:0]      ea;
        logic [DW-1:0]      ewd, erd;
        #1;
        eg = '0; een = 1'b0; ewe = 1'b0; ea = '0; ewd = '0; erv = '0; erd = m_rd;
        if (m_owner >= 0) begin
            eg  = NUM_REQ'(1) << m_owner;
            een = bit_of(req, m_owner);
            ewe = een & bit_of(m_we, m_owner);
            ea  = AW'(m_addr >> (m_owner * AW));
            ewd = DW'(m_wdata >> (m_owner * DW));
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv = NUM_REQ'(1) << rq[0].who;
            erd = rq[0].data;
        end
        if (een && !ewe) rq.push_back(rd_t'{cyc + 2, m_owner, ram[ea[7:0]]});
        e_gnt = eg; e_en = een; e_we = ewe; e_rdv = erv;
        exp_v = {eg, een, ewe, ea, ewd, erv, erd};
    endtask

    task automatic advance();
        logic [NUM_REQ-1:0] r;
        int  w;
        logic others, rel;
        r = req;
        @(posedge clk);
        if (e_rdv != '0) begin
            m_rd = rq[0].data;
            void'(rq.pop_front());
        end
        if (m_owner < 0) begin
            w = pick(r);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_acc = 0;
            end
        end else begin
            others = (r & ~e_gnt) != '0;
            if (e_en) m_acc++;
            rel = !bit_of(r, m_owner);
`ifdef CPU_PRIORITY_EN
            if (m_owner != 0 && e_en && (r[0] || (m_acc >= MAX_BURST && others))) rel = 1'b1;
`else
            if (e_en && m_acc >= MAX_BURST && others) rel = 1'b1;
`endif
            if (rel) m_owner = -1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_bus();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_addr[i*AW +: AW]  = AW'($urandom);
            m_wdata[i*DW +: DW] = DW'($urandom);
        end
        m_we = NUM_REQ'($urandom);
    endtask

    task automatic settle(input int n);
        req = '0;
        for (int c = 0; c < n; c++) begin
            rand_bus();
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL settle c%0d: got %h want %h", cyc, obs, exp_v); end
            advance();
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        predict();
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        n_vec++;
        if (gnt !== 3'b000 || rd_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_gnt: got gnt=%b rd_data=%h want 000/0000", gnt, rd_data);
        end
        n_reset = 1'b1;
        advance();
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[3];
        int gap;
        logic [NUM_REQ-1:0] prev_g;
`ifdef CPU_PRIORITY_EN
        req = 3'b110; exp_order = '{1, 2, 1};
`else
        req = 3'b111; exp_order = '{0, 1, 2};
`endif
        prev_g = '0; gap = 0;
        for (int c = 0; c < 60 && order.size() < 3; c++) begin
            rand_bus();
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL rr c%0d: got %h want %h", cyc, obs, exp_v); end
            if (gnt != '0 && prev_g == '0) begin
                if (order.size() > 0) begin
                    n_vec++;
                    if (gap != 1) begin n_err++; $display("FAIL rr_gap: got %0d dead cycles want 1", gap); end
                end
                order.push_back(idx_of(gnt));
                gap = 0;
            end else if (gnt == '0) gap++;
            prev_g = gnt;
            advance();
        end
        n_vec++;
        if (order.size() != 3) begin
            n_err++; $display("FAIL rr_timeout: got %0d grants want 3", order.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (order[i] != exp_order[i]) begin
                    n_err++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
        settle(4);
    endtask

    task automatic test_sole_requester();
        int pulses;
        pulses = 0;
        req = 3'b010;
        for (int c = 0; c <= 20; c++) begin
            rand_bus();
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL sole c%0d: got %h want %h", cyc, obs, exp_v); end
            n_vec++;
            if (c == 0 && gnt !== 3'b000) begin
                n_err++; $display("FAIL sole_latency: got %b want 000", gnt);
            end else if (c > 0 && gnt !== 3'b010) begin
                n_err++; $display("FAIL sole_gnt c%0d: got %b want 010", c, gnt);
            end
            if (mem_en === 1'b1) pulses++;
            advance();
        end
        n_vec++;
        if (pulses != 20) begin n_err++; $display("FAIL sole_pulses: got %0d want 20", pulses); end
        settle(4);
    endtask

    task automatic test_burst_limit();
        int acc1, zeros;
        logic done;
        acc1 = 0; zeros = 0; done = 1'b0;
        req = 3'b010;
        for (int c = 0; c < 40 && !done; c++) begin
            rand_bus();
            if (acc1 >= 3) req = 3'b110;
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL burst c%0d: got %h want %h", cyc, obs, exp_v); end
            if (gnt === 3'b010 && mem_en === 1'b1) acc1++;
            else if (gnt === 3'b000 && acc1 > 0) zeros++;
            else if (gnt === 3'b100) done = 1'b1;
            advance();
        end
        n_vec++;
        if (!done || acc1 != MAX_BURST || zeros != 1) begin
            n_err++;
            $display("FAIL burst_limit: got done=%0d acc=%0d dead=%0d want 1/%0d/1", done, acc1, zeros, MAX_BURST);
        end
        settle(4);
    endtask

    task automatic test_read_return();
        for (int c = 0; c < 7; c++) begin
            rand_bus();
            m_addr[2*AW +: AW]  = 16'h0040;
            m_wdata[2*DW +: DW] = 16'hBEEF;
            m_we = (c <= 1) ? 3'b100 : 3'b000;
            req  = (c <= 2) ? 3'b100 : 3'b000;
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL read c%0d: got %h want %h", cyc, obs, exp_v); end
            if (c == 3 || c == 5) begin
                n_vec++;
                if (rd_valid !== 3'b000) begin n_err++; $display("FAIL read_idle c%0d: got %b want 000", c, rd_valid); end
            end
            if (c == 4) begin
                n_vec++;
                if (rd_valid !== 3'b100 || rd_data !== 16'hBEEF) begin
                    n_err++; $display("FAIL read_return: got %b/%h want 100/beef", rd_valid, rd_data);
                end
            end
            advance();
        end
        settle(3);
    endtask

    task automatic test_reset_mid_burst();
        req = 3'b010;
        for (int c = 0; c < 5; c++) begin
            rand_bus();
            m_we = '0;
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL midrst c%0d: got %h want %h", cyc, obs, exp_v); end
            if (c < 4) advance();
        end
        n_reset = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 3'b000 || mem_en !== 1'b0 || rd_valid !== 3'b000 || rd_data !== 16'h0000) begin
            n_err++;
            $display("FAIL midrst_async: got gnt=%b en=%b rdv=%b rd=%h want 000/0/000/0000", gnt, mem_en, rd_valid, rd_data);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        n_reset = 1'b1;
        req = 3'b111;
        for (int c = 0; c < 2; c++) begin
            rand_bus();
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL resume c%0d: got %h want %h", cyc, obs, exp_v); end
            if (c == 1) begin
                n_vec++;
                if (gnt !== 3'b001) begin n_err++; $display("FAIL resume_first: got %b want 001", gnt); end
            end
            advance();
        end
        settle(4);
    endtask

`ifdef CPU_PRIORITY_EN
    task automatic test_cpu_priority();
        int acc2, after, zeros;
        logic done;
        acc2 = 0; after = 0; zeros = 0; done = 1'b0;
        req = 3'b100;
        for (int c = 0; c < 20 && !done; c++) begin
            rand_bus();
            if (acc2 >= 2) req = 3'b101;
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL prio c%0d: got %h want %h", cyc, obs, exp_v); end
            if (gnt === 3'b100 && mem_en === 1'b1) begin
                acc2++;
                if (req[0]) after++;
            end else if (gnt === 3'b000 && acc2 > 0) zeros++;
            else if (gnt === 3'b001) done = 1'b1;
            advance();
        end
        n_vec++;
        if (!done || after != 1 || zeros != 1) begin
            n_err++; $display("FAIL prio_preempt: got done=%0d extra=%0d dead=%0d want 1/1/1", done, after, zeros);
        end
        settle(4);
    endtask
`endif

    task automatic test_random();
        req = '0;
        for (int c = 0; c < 400; c++) begin
            rand_bus();
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(0, 40) == 0) req = '0;
            predict();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL random c%0d: got %h want %h", cyc, obs, exp_v); end
            advance();
        end
        settle(4);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_burst_limit();
        test_read_return();
        test_reset_mid_burst();
`ifdef CPU_PRIORITY_EN
        test_cpu_priority();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
